// File: rtl/wc_fifo_pkg.sv
// -----------------------------------------------------------------------------
// wc_fifo_pkg
// Shared helpers for the width-up-converting prefetch FIFO:
//   clog2_f       - constant-foldable ceil(log2()).
//   out_width_f   - output word width from beat width and ratio.
//   lane_w_f      - width of a lane count (1..RATIO).
//   ptr_w_f       - storage pointer width.
//   lane_lsb_f    - bit offset at which a beat placed in a lane starts.
// -----------------------------------------------------------------------------
package wc_fifo_pkg;

    localparam int WC_DEF_IN_WIDTH = 16;
    localparam int WC_DEF_RATIO    = 16;
    localparam int WC_DEF_DEPTH    = 64;

    function automatic int clog2_f(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    function automatic int out_width_f(input int in_width, input int ratio);
        return in_width * ratio;
    endfunction

    function automatic int lane_w_f(input int ratio);
        return clog2_f(ratio) + 1;
    endfunction

    function automatic int ptr_w_f(input int depth);
        return clog2_f(depth);
    endfunction

    // Lane 0 sits in the LSBs; lane n starts n beats up.
    function automatic int lane_lsb_f(input int lane, input int in_width);
        return lane * in_width;
    endfunction

endpackage

// File: rtl/wc_fifo_packer.sv
// -----------------------------------------------------------------------------
// wc_fifo_packer
// Gathers IN_WIDTH beats into OUT_WIDTH words. A word closes on its last lane
// or on wr_last; the closing beat is merged combinationally so commit happens
// on the same edge that accepts it.
// Ports:
//   clk, rst_n     - clock, async active-low reset
//   wr_en, wr_vld  - beat offered / ready from the FIFO (accept = both high)
//   wr_data        - incoming beat
//   wr_last        - close the current word with this beat
//   commit         - a word is written to storage this edge
//   commit_data    - assembled word, unused upper lanes zero
//   commit_lanes   - number of valid lanes in commit_data
// -----------------------------------------------------------------------------
module wc_fifo_packer
    import wc_fifo_pkg::*;
#(
    parameter int IN_WIDTH = WC_DEF_IN_WIDTH,
    parameter int RATIO    = WC_DEF_RATIO,
    localparam int OUT_WIDTH = out_width_f(IN_WIDTH, RATIO),
    localparam int LW        = lane_w_f(RATIO)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic                 wr_vld,
    input  logic [IN_WIDTH-1:0]  wr_data,
    input  logic                 wr_last,
    output logic                 commit,
    output logic [OUT_WIDTH-1:0] commit_data,
    output logic [LW-1:0]        commit_lanes
);

    localparam int LCW = LW - 1;
    localparam logic [LCW-1:0] LANE_MAX = LCW'(RATIO - 1);

    logic [LCW-1:0]       lane_q;
    logic [OUT_WIDTH-1:0] pack_q;
    logic                 accept;
    logic                 is_final;

    always_comb begin
        accept      = wr_en && wr_vld;
        is_final    = (lane_q == LANE_MAX) || wr_last;
        commit      = accept && is_final;
        // pack_q only ever holds lanes below lane_q, so upper lanes stay zero.
        commit_data = pack_q;
        for (int l = 0; l < RATIO; l++) begin
            if (lane_q == LCW'(l))
                commit_data[lane_lsb_f(l, IN_WIDTH) +: IN_WIDTH] = wr_data;
        end
        commit_lanes = {1'b0, lane_q} + LW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q <= '0;
            pack_q <= '0;
        end else if (accept) begin
            if (is_final) begin
                lane_q <= '0;
                pack_q <= '0;
            end else begin
                lane_q <= lane_q + LCW'(1);
                pack_q <= commit_data;
            end
        end
    end

endmodule

// File: rtl/wc_prefetch_fifo.sv
// -----------------------------------------------------------------------------
// wc_prefetch_fifo
// Width-up-converting FIFO with first-word-fall-through output. Beats are
// packed by wc_fifo_packer and stored as DEPTH words of IN_WIDTH*RATIO bits.
// Ports:
//   clk, rst_n       - clock, async active-low reset
//   wr_en / wr_vld   - write request / write ready
//   wr_data, wr_last - beat and early word close
//   rd_en / rd_vld   - pop request / head word valid
//   rd_data          - head word, lane 0 in LSBs
//   rd_lanes         - valid lanes in head word
//   rd_level         - stored word count (only with WC_FIFO_LEVEL_EN)
// Build option: define WC_FIFO_LEVEL_EN to add the rd_level port.
// -----------------------------------------------------------------------------
module wc_prefetch_fifo
    import wc_fifo_pkg::*;
#(
    parameter int IN_WIDTH = WC_DEF_IN_WIDTH,
    parameter int RATIO    = WC_DEF_RATIO,
    parameter int DEPTH    = WC_DEF_DEPTH,
    localparam int OUT_WIDTH = out_width_f(IN_WIDTH, RATIO),
    localparam int LW        = lane_w_f(RATIO),
    localparam int PW        = ptr_w_f(DEPTH),
    localparam int CW        = PW + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    output logic                 wr_vld,
    input  logic [IN_WIDTH-1:0]  wr_data,
    input  logic                 wr_last,
    input  logic                 rd_en,
    output logic                 rd_vld,
    output logic [OUT_WIDTH-1:0] rd_data,
    output logic [LW-1:0]        rd_lanes
`ifdef WC_FIFO_LEVEL_EN
    ,
    output logic [CW-1:0]        rd_level
`endif
);

    logic [OUT_WIDTH-1:0] mem_data  [DEPTH];
    logic [LW-1:0]        mem_lanes [DEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [CW-1:0]        count;
    logic                 rdy_q;
    logic                 commit;
    logic [OUT_WIDTH-1:0] commit_data;
    logic [LW-1:0]        commit_lanes;
    logic                 pop;

    wc_fifo_packer #(
        .IN_WIDTH (IN_WIDTH),
        .RATIO    (RATIO)
    ) u_packer (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_vld       (wr_vld),
        .wr_data      (wr_data),
        .wr_last      (wr_last),
        .commit       (commit),
        .commit_data  (commit_data),
        .commit_lanes (commit_lanes)
    );

    // Ready depends only on registered state, never on rd_en.
    assign wr_vld   = rdy_q && (count < CW'(DEPTH));
    assign rd_vld   = (count != '0);
    assign pop      = rd_en && rd_vld;
    // Gated so the unreset storage array never shows through when empty.
    assign rd_data  = rd_vld ? mem_data[rd_ptr]  : '0;
    assign rd_lanes = rd_vld ? mem_lanes[rd_ptr] : '0;

`ifdef WC_FIFO_LEVEL_EN
    assign rd_level = count;
`endif

    always_ff @(posedge clk) begin
        if (commit) begin
            mem_data[wr_ptr]  <= commit_data;
            mem_lanes[wr_ptr] <= commit_lanes;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q  <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            rdy_q <= 1'b1;
            if (commit)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({commit, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_wc_prefetch_fifo.sv
module tb_wc_prefetch_fifo;

    localparam int IW = 16;
    localparam int R  = 16;
    localparam int D  = 4;
    localparam int OW = IW * R;
    localparam int LW = 5;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic          wr_last = 1'b0;
    logic          rd_en = 1'b0;
    logic [IW-1:0] wr_data = '0;
    logic          wr_vld;
    logic          rd_vld;
    logic [OW-1:0] rd_data;
    logic [LW-1:0] rd_lanes;
`ifdef WC_FIFO_LEVEL_EN
    logic [CW-1:0] rd_level;
`endif

    wc_prefetch_fifo #(.IN_WIDTH(IW), .RATIO(R), .DEPTH(D)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_vld   (wr_vld),
        .wr_data  (wr_data),
        .wr_last  (wr_last),
        .rd_en    (rd_en),
        .rd_vld   (rd_vld),
        .rd_data  (rd_data),
        .rd_lanes (rd_lanes)
`ifdef WC_FIFO_LEVEL_EN
        ,
        .rd_level (rd_level)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a queue of finished words plus the beats of the open word.
    typedef struct {
        logic [OW-1:0] data;
        int            lanes;
    } word_t;

    word_t         m_q[$];
    logic [IW-1:0] m_part[$];
    bit            m_ready = 1'b0;

    function bit exp_wr_vld();
        return m_ready && (m_q.size() < D);
    endfunction

    function logic [OW-1:0] exp_data();
        return (m_q.size() != 0) ? m_q[0].data : '0;
    endfunction

    function int exp_lanes();
        return (m_q.size() != 0) ? m_q[0].lanes : 0;
    endfunction

    task automatic tick();
        bit    acc;
        bit    pop;
        word_t w;
        acc = wr_en && exp_wr_vld();
        pop = rd_en && (m_q.size() != 0);
        @(posedge clk);
        if (pop) m_q.delete(0);
        if (acc) begin
            m_part.push_back(wr_data);
            if (m_part.size() == R || wr_last) begin
                w.data = '0;
                foreach (m_part[i]) w.data[i*IW +: IW] = m_part[i];
                w.lanes = m_part.size();
                m_q.push_back(w);
                m_part.delete();
            end
        end
        m_ready = 1'b1;
        #1;
    endtask

    task automatic reset_assert();
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_last = 1'b0;
        m_ready = 1'b0;
        m_q.delete();
        m_part.delete();
        #2;
    endtask

    task automatic reset_release();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (wr_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL rel_wr_vld_pre: got %b want 0", wr_vld);
        end
        tick();
        n_tests++;
        if (wr_vld !== 1'b1) begin
            n_fail++;
            $display("FAIL rel_wr_vld_post: got %b want 1", wr_vld);
        end
    endtask

    task automatic test_reset();
        reset_assert();
        n_tests += 4;
        if (wr_vld !== 1'b0) begin n_fail++; $display("FAIL rst_wr_vld: got %b want 0", wr_vld); end
        if (rd_vld !== 1'b0) begin n_fail++; $display("FAIL rst_rd_vld: got %b want 0", rd_vld); end
        if (rd_data !== '0) begin n_fail++; $display("FAIL rst_rd_data: got %h want 0", rd_data); end
        if (rd_lanes !== '0) begin n_fail++; $display("FAIL rst_rd_lanes: got %0d want 0", rd_lanes); end
        reset_release();
    endtask

    task automatic test_full_word();
        for (int i = 0; i < R; i++) begin
            wr_en = 1'b1; wr_data = IW'(i); wr_last = 1'b0;
            tick();
            n_tests++;
            if (rd_vld !== (i == R - 1)) begin
                n_fail++;
                $display("FAIL fw_rd_vld beat %0d: got %b want %b", i, rd_vld, (i == R - 1));
            end
        end
        wr_en = 1'b0;
        n_tests += 4;
        if (rd_data[15:0] !== 16'h0000) begin n_fail++; $display("FAIL fw_lane0: got %h want 0000", rd_data[15:0]); end
        if (rd_data[255:240] !== 16'h000F) begin n_fail++; $display("FAIL fw_lane15: got %h want 000f", rd_data[255:240]); end
        if (rd_lanes !== LW'(16)) begin n_fail++; $display("FAIL fw_lanes: got %0d want 16", rd_lanes); end
        if (rd_data !== exp_data()) begin n_fail++; $display("FAIL fw_data: got %h want %h", rd_data, exp_data()); end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        n_tests++;
        if (rd_vld !== 1'b0) begin n_fail++; $display("FAIL fw_pop_empty: got %b want 0", rd_vld); end
    endtask

    task automatic test_wr_last();
        logic [OW-1:0] want;
        want = '0;
        want[47:0] = 48'h00A3_00A2_00A1;
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_data = IW'(16'hA1 + i); wr_last = (i == 2);
            tick();
        end
        wr_data = 16'h0055; wr_last = 1'b1;
        tick();
        wr_en = 1'b0; wr_last = 1'b0;
        n_tests += 2;
        if (rd_lanes !== LW'(3)) begin n_fail++; $display("FAIL wl_lanes: got %0d want 3", rd_lanes); end
        if (rd_data !== want) begin n_fail++; $display("FAIL wl_data: got %h want %h", rd_data, want); end
        rd_en = 1'b1;
        tick();
        n_tests += 3;
        if (rd_vld !== 1'b1) begin n_fail++; $display("FAIL wl_next_vld: got %b want 1", rd_vld); end
        if (rd_lanes !== LW'(1)) begin n_fail++; $display("FAIL wl_next_lanes: got %0d want 1", rd_lanes); end
        if (rd_data !== OW'(16'h0055)) begin n_fail++; $display("FAIL wl_next_data: got %h want 55", rd_data); end
        tick();
        rd_en = 1'b0;
        n_tests++;
        if (rd_vld !== 1'b0) begin n_fail++; $display("FAIL wl_empty: got %b want 0", rd_vld); end
    endtask

    task automatic test_back_to_back();
        for (int w = 0; w < D; w++) begin
            for (int i = 0; i < R; i++) begin
                wr_en = 1'b1; wr_data = IW'(w * 256 + i); wr_last = 1'b0;
                tick();
            end
        end
        wr_data = 16'hBEEF;
        for (int k = 0; k < 2; k++) begin
            tick();
            n_tests++;
            if (wr_vld !== 1'b0) begin n_fail++; $display("FAIL bb_full_wr_vld %0d: got %b want 0", k, wr_vld); end
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        n_tests += 3;
        if (wr_vld !== 1'b1) begin n_fail++; $display("FAIL bb_after_pop_wr_vld: got %b want 1", wr_vld); end
        if (rd_data[15:0] !== 16'h0100) begin n_fail++; $display("FAIL bb_head: got %h want 0100", rd_data[15:0]); end
        if (rd_data !== exp_data()) begin n_fail++; $display("FAIL bb_head_full: got %h want %h", rd_data, exp_data()); end
        tick();
        wr_en = 1'b0;
        rd_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n_tests += 2;
            if (rd_vld !== 1'b1) begin n_fail++; $display("FAIL bb_stream_vld %0d: got %b want 1", k, rd_vld); end
            if (rd_data !== exp_data()) begin n_fail++; $display("FAIL bb_stream_data %0d: got %h want %h", k, rd_data, exp_data()); end
            tick();
        end
        rd_en = 1'b0;
        n_tests++;
        if (rd_vld !== 1'b0) begin n_fail++; $display("FAIL bb_drained: got %b want 0", rd_vld); end
        wr_en = 1'b1; wr_data = 16'h1234; wr_last = 1'b1;
        tick();
        wr_en = 1'b0; wr_last = 1'b0;
        n_tests += 2;
        if (rd_lanes !== LW'(2)) begin n_fail++; $display("FAIL bb_held_lanes: got %0d want 2", rd_lanes); end
        if (rd_data[31:0] !== 32'h1234_BEEF) begin n_fail++; $display("FAIL bb_held_data: got %h want 1234beef", rd_data[31:0]); end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic test_reset_midword();
        for (int i = 0; i < 7; i++) begin
            wr_en = 1'b1; wr_data = IW'(16'h7000 + i); wr_last = 1'b0;
            tick();
        end
        reset_assert();
        n_tests += 4;
        if (wr_vld !== 1'b0) begin n_fail++; $display("FAIL mw_wr_vld: got %b want 0", wr_vld); end
        if (rd_vld !== 1'b0) begin n_fail++; $display("FAIL mw_rd_vld: got %b want 0", rd_vld); end
        if (rd_data !== '0) begin n_fail++; $display("FAIL mw_rd_data: got %h want 0", rd_data); end
        if (rd_lanes !== '0) begin n_fail++; $display("FAIL mw_rd_lanes: got %0d want 0", rd_lanes); end
        reset_release();
        for (int i = 0; i < R; i++) begin
            wr_en = 1'b1; wr_data = IW'(16'hC000 + i); wr_last = 1'b0;
            tick();
        end
        wr_en = 1'b0;
        n_tests += 3;
        if (rd_lanes !== LW'(16)) begin n_fail++; $display("FAIL mw_lanes: got %0d want 16", rd_lanes); end
        if (rd_data[127:112] !== 16'hC007) begin n_fail++; $display("FAIL mw_lane7: got %h want c007", rd_data[127:112]); end
        if (rd_data !== exp_data()) begin n_fail++; $display("FAIL mw_data: got %h want %h", rd_data, exp_data()); end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            wr_en   = ($urandom_range(0, 3) != 0);
            wr_data = IW'($urandom);
            wr_last = ($urandom_range(0, 7) == 0);
            rd_en   = (c < 300) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 2) != 0);
            tick();
            n_tests += 4;
            if (wr_vld !== exp_wr_vld()) begin n_fail++; $display("FAIL rnd_wr_vld c%0d: got %b want %b", c, wr_vld, exp_wr_vld()); end
            if (rd_vld !== (m_q.size() != 0)) begin n_fail++; $display("FAIL rnd_rd_vld c%0d: got %b want %b", c, rd_vld, (m_q.size() != 0)); end
            if (rd_lanes !== LW'(exp_lanes())) begin n_fail++; $display("FAIL rnd_lanes c%0d: got %0d want %0d", c, rd_lanes, exp_lanes()); end
            if (rd_data !== exp_data()) begin n_fail++; $display("FAIL rnd_data c%0d: got %h want %h", c, rd_data, exp_data()); end
        end
        wr_en = 1'b0; wr_last = 1'b0; rd_en = 1'b0;
    endtask

`ifdef WC_FIFO_LEVEL_EN
    task automatic test_level();
        int want [4] = '{1, 2, 3, 2};
        rd_en = 1'b1; wr_en = 1'b0;
        for (int k = 0; k < 2 * D && m_q.size() != 0; k++) tick();
        rd_en = 1'b0;
        n_tests++;
        if (rd_level !== '0) begin n_fail++; $display("FAIL lvl_empty: got %0d want 0", rd_level); end
        for (int k = 0; k < 4; k++) begin
            wr_en = (k < 3); wr_last = 1'b1; wr_data = IW'(k);
            rd_en = (k == 3);
            tick();
            n_tests++;
            if (rd_level !== CW'(want[k])) begin n_fail++; $display("FAIL lvl_step %0d: got %0d want %0d", k, rd_level, want[k]); end
        end
        wr_en = 1'b0; wr_last = 1'b0; rd_en = 1'b0;
    endtask
`endif

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_full_word();
        test_wr_last();
        test_back_to_back();
        test_reset_midword();
        test_random();
`ifdef WC_FIFO_LEVEL_EN
        test_level();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
